// File: rtl/lut_share_pkg.sv
// Shared constants and request type for the shared soft-LUT arbiter.
package lut_share_pkg;

  localparam int LUT_W = 16;
  localparam int SEL_W = 4;

  // Canonical single-input patterns: each one makes the LUT output equal one input.
  // IA follows d, IB follows c, IC follows b, ID follows a.
  localparam logic [LUT_W-1:0] IA = 16'hFF00;
  localparam logic [LUT_W-1:0] IB = 16'hF0F0;
  localparam logic [LUT_W-1:0] IC = 16'hCCCC;
  localparam logic [LUT_W-1:0] ID = 16'hAAAA;

  // One request payload. The field is called tbl because "table" is a reserved word.
  typedef struct packed {
    logic [LUT_W-1:0] tbl;
    logic [SEL_W-1:0] sel;
  } lut_req_t;

endpackage

// File: rtl/lut_share_arbiter_if.sv
// Request/response bundle between the requesters and the shared LUT arbiter.
interface lut_share_arbiter_if
  import lut_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) ();

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*LUT_W-1:0] req_table;
  logic [NREQ*SEL_W-1:0] req_sel;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic                  resp_o;
  logic [7:0]            busy_cnt;

  // Requester/consumer side.
  modport master (
    output req_valid, req_table, req_sel, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_o, busy_cnt
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_table, req_sel, resp_ready,
    output req_ready, resp_valid, resp_id, resp_o, busy_cnt
  );

endinterface

// File: rtl/lut_eval.sv
// Combinational 4-input soft LUT: the output is tbl indexed by sel = {d,c,b,a}.
module lut_eval
  import lut_share_pkg::*;
(
  input  logic [LUT_W-1:0] tbl,
  input  logic [SEL_W-1:0] sel,
  output logic             o
);

  assign o = tbl[sel];

endmodule

// File: rtl/lut_share_arbiter.sv
// Shares one soft-LUT evaluator among NREQ requesters. One request is granted per
// cycle (round-robin or fixed priority), and the result is returned through a
// single registered response stage together with the requester id.
module lut_share_arbiter
  import lut_share_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int ID_W        = $clog2(NREQ)
) (
  input logic               clk,
  input logic               rst_n,
  lut_share_arbiter_if.slave bus
);

  lut_req_t        req_arr [NREQ];
  lut_req_t        win_req;
  logic            resp_valid_reg;
  logic [ID_W-1:0] resp_id_reg;
  logic            resp_o_reg;
  logic [7:0]      busy_cnt_reg;
  logic [ID_W-1:0] rr_ptr_reg;
  logic [ID_W-1:0] rr_ptr_next;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   search_idx;
  logic [NREQ-1:0] grant_onehot;
  logic            found;
  logic            grant;
  logic            can_take;
  logic            eval_o;

  // Unpack each requester's slice of the flat buses into a request struct.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_arr[gi].tbl = bus.req_table[LUT_W*gi +: LUT_W];
      assign req_arr[gi].sel = bus.req_sel[SEL_W*gi +: SEL_W];
    end
  endgenerate

  // The output stage can take a new result when it is empty or is being drained.
  assign can_take = !resp_valid_reg || bus.resp_ready;

  // Winner search: walk from rr_ptr (or from 0 for fixed priority) and take the first valid.
  always_comb begin
    found      = 1'b0;
    grant_idx  = '0;
    search_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (ROUND_ROBIN) begin
        search_idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
        if (search_idx >= (ID_W+1)'(NREQ)) begin
          search_idx = search_idx - (ID_W+1)'(NREQ);
        end
      end else begin
        search_idx = (ID_W+1)'(k);
      end
      if (!found && bus.req_valid[search_idx[ID_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = search_idx[ID_W-1:0];
      end
    end
  end

  // Grant is re-evaluated every cycle; nothing is granted while reset is asserted.
  always_comb begin
    grant        = found && can_take && rst_n;
    grant_onehot = '0;
    if (grant) begin
      grant_onehot[grant_idx] = 1'b1;
    end
    if (grant_idx == ID_W'(NREQ - 1)) begin
      rr_ptr_next = '0;
    end else begin
      rr_ptr_next = grant_idx + ID_W'(1);
    end
  end

  // Only the winner's payload reaches the evaluator, so other requesters' data is ignored.
  assign win_req = req_arr[grant_idx];

  lut_eval u_eval (
    .tbl (win_req.tbl),
    .sel (win_req.sel),
    .o   (eval_o)
  );

  // Response stage, rotating pointer and blocked-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_reg <= 1'b0;
      resp_id_reg    <= '0;
      resp_o_reg     <= 1'b0;
      busy_cnt_reg   <= '0;
      rr_ptr_reg     <= '0;
    end else begin
      if (grant) begin
        resp_valid_reg <= 1'b1;
        resp_id_reg    <= grant_idx;
        resp_o_reg     <= eval_o;
        rr_ptr_reg     <= rr_ptr_next;
      end else if (bus.resp_ready) begin
        resp_valid_reg <= 1'b0;
      end
      if (|bus.req_valid && !can_take && busy_cnt_reg != 8'hFF) begin
        busy_cnt_reg <= busy_cnt_reg + 8'd1;
      end
    end
  end

  assign bus.req_ready  = grant_onehot;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_id    = resp_id_reg;
  assign bus.resp_o     = resp_o_reg;
  assign bus.busy_cnt   = busy_cnt_reg;

endmodule
